// File: rtl/button_debouncer.sv
// Two-channel push-button conditioner.
// Each raw button input goes through a 2-flop synchroniser and then a
// 4-state debounce FSM. A level change is accepted only after the
// synchronised input has held the new value for CNT_MAX consecutive cycles.
// The debounced levels a/b are registered and feed andGate.a/andGate.b.
//
// Build option: define DEBOUNCE_RISE_PULSE_EN to compile in the one-cycle
// rising-edge pulses a_rise/b_rise. Without it both pulse outputs are
// tied to 0. The port list and the level behaviour are the same in both builds.

module debounce_channel #(
    parameter int CNT_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic rise
);

    // state    | meaning
    // ---------+---------------------------------------------------
    // LOW      | output 0, input stable low
    // RISE_CHK | output 0, input seen high, counting stable cycles
    // HIGH     | output 1, input stable high
    // FALL_CHK | output 1, input seen low, counting stable cycles
    //
    // Bit 1 of the encoding is the debounced level, so the output comes
    // straight from a state flop and has no combinational input path.
    typedef enum logic [1:0] {
        LOW      = 2'b00,
        RISE_CHK = 2'b01,
        HIGH     = 2'b11,
        FALL_CHK = 2'b10
    } state_t;

    localparam int CW = $clog2(CNT_MAX);
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    state_t        state;

    // Bring the asynchronous button into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

`ifdef DEBOUNCE_RISE_PULSE_EN
    logic rise_q;

    // Debounce FSM with stability counter and registered rise pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= LOW;
            cnt    <= '0;
            rise_q <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            case (state)
                LOW: begin
                    if (s2) begin
                        state <= RISE_CHK;
                        cnt   <= CW'(1);
                    end else begin
                        cnt   <= '0;
                    end
                end
                RISE_CHK: begin
                    if (!s2) begin
                        state <= LOW;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state  <= HIGH;
                        cnt    <= '0;
                        rise_q <= 1'b1;
                    end else begin
                        cnt   <= cnt + CW'(1);
                    end
                end
                HIGH: begin
                    if (!s2) begin
                        state <= FALL_CHK;
                        cnt   <= CW'(1);
                    end else begin
                        cnt   <= '0;
                    end
                end
                FALL_CHK: begin
                    if (s2) begin
                        state <= HIGH;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= LOW;
                        cnt   <= '0;
                    end else begin
                        cnt   <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= LOW;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign rise = rise_q;
`else
    // Debounce FSM with stability counter; no pulse logic in this build.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOW;
            cnt   <= '0;
        end else begin
            case (state)
                LOW: begin
                    if (s2) begin
                        state <= RISE_CHK;
                        cnt   <= CW'(1);
                    end else begin
                        cnt   <= '0;
                    end
                end
                RISE_CHK: begin
                    if (!s2) begin
                        state <= LOW;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= HIGH;
                        cnt   <= '0;
                    end else begin
                        cnt   <= cnt + CW'(1);
                    end
                end
                HIGH: begin
                    if (!s2) begin
                        state <= FALL_CHK;
                        cnt   <= CW'(1);
                    end else begin
                        cnt   <= '0;
                    end
                end
                FALL_CHK: begin
                    if (s2) begin
                        state <= HIGH;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= LOW;
                        cnt   <= '0;
                    end else begin
                        cnt   <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= LOW;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign rise = 1'b0;
`endif

    assign level = state[1];

endmodule

module button_debouncer #(
    parameter int CNT_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_a,
    input  logic btn_b,
    output logic a,
    output logic b,
    output logic a_rise,
    output logic b_rise
);

    // Two fully independent channels; nothing is shared between them.
    debounce_channel #(.CNT_MAX(CNT_MAX)) u_chan_a (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_a),
        .level (a),
        .rise  (a_rise)
    );

    debounce_channel #(.CNT_MAX(CNT_MAX)) u_chan_b (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_b),
        .level (b),
        .rise  (b_rise)
    );

endmodule
